// File: rtl/ex_muldiv_pkg.sv
// Shared types and constants for the RV32M iterative multiply/divide engine.
// Pure declarations: no timing or flow control lives here.
package ex_muldiv_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 5;

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_DIVU   = 3'b101;
    localparam logic [2:0] F_REM    = 3'b110;
    localparam logic [2:0] F_REMU   = 3'b111;

    localparam logic [XLEN-1:0] INT_MIN  = 32'h8000_0000;
    localparam logic [XLEN-1:0] ALL_ONES = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Two's-complement magnitude when the sign flag is set.
    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic neg);
        return neg ? (~v + XLEN'(1)) : v;
    endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// EX-stage bundle between the ID/EX register and the mul/div engine.
// master = pipeline side, slave = engine side.
interface ex_muldiv_if;
    import ex_muldiv_pkg::*;

    logic            start;
    logic            flush;
    logic [2:0]      fnc3;
    logic [XLEN-1:0] opa;
    logic [XLEN-1:0] opb;
    logic [4:0]      rd;
    logic            stall;
    logic            done;
    logic [XLEN-1:0] result;
    logic [4:0]      rdo;

    modport master (
        output start, flush, fnc3, opa, opb, rd,
        input  stall, done, result, rdo
    );

    modport slave (
        input  start, flush, fnc3, opa, opb, rd,
        output stall, done, result, rdo
    );

endinterface

// File: rtl/ex_muldiv_step.sv
// One radix-2 iteration on {acc, opr}: shift-add (multiply) or restoring subtract (divide).
// Purely combinational, zero latency, no flow control.
module ex_muldiv_step
    import ex_muldiv_pkg::*;
(
    input  logic            is_div,
    input  logic [XLEN:0]   acc,
    input  logic [XLEN-1:0] opr,
    input  logic [XLEN-1:0] opd,
    output logic [XLEN:0]   acc_nxt,
    output logic [XLEN-1:0] opr_nxt
);

    logic [XLEN:0] sum;
    logic [XLEN:0] rem_sh;
    logic [XLEN:0] diff;
    logic          ge;

    always_comb begin
        // acc stays below opd, so the XLEN+1 bit width absorbs the carry/shift-out.
        sum     = acc + {1'b0, (opr[0] ? opd : '0)};
        rem_sh  = {acc[XLEN-1:0], opr[XLEN-1]};
        diff    = rem_sh - {1'b0, opd};
        ge      = (rem_sh >= {1'b0, opd});
        acc_nxt = '0;
        opr_nxt = '0;
        if (is_div) begin
            acc_nxt = ge ? diff : rem_sh;
            opr_nxt = {opr[XLEN-2:0], ge};
        end else begin
            acc_nxt = {1'b0, sum[XLEN:1]};
            opr_nxt = {sum[0], opr[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M engine: 34-cycle ops (accept + 32 steps + DONE), 2 cycles for div-by-zero/overflow.
// Stalls the pipeline front while accepting or calculating; flush abandons the op silently.
module ex_muldiv_unit
    import ex_muldiv_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    ex_muldiv_if.slave   bus
);

    state_t          state, state_nxt;
    logic [CNT_W-1:0] count;
    logic [2:0]      fnc;
    logic [4:0]      rd_q, rdo_q;
    logic [XLEN:0]   acc, acc_nxt;
    logic [XLEN-1:0] opr, opr_nxt, opd, result_q;
    logic            neg_res, neg_rem;

    logic            accept, last, sgn_a, sgn_b, is_sdiv, div0, ovf, special;
    logic [XLEN-1:0] special_res, final_res;
    logic [2*XLEN-1:0] prod, prod_s;

    assign accept  = (state == ST_IDLE) && bus.start && !bus.flush;
    assign last    = (state == ST_CALC) && (count == CNT_W'(XLEN-1));
    assign is_sdiv = (bus.fnc3 == F_DIV) || (bus.fnc3 == F_REM);
    assign sgn_a   = bus.opa[XLEN-1] && (bus.fnc3 != F_MULHU) && (bus.fnc3 != F_DIVU)
                     && (bus.fnc3 != F_REMU);
    assign sgn_b   = bus.opb[XLEN-1] && ((bus.fnc3 == F_MUL) || (bus.fnc3 == F_MULH) || is_sdiv);
    assign div0    = bus.fnc3[2] && (bus.opb == '0);
    assign ovf     = is_sdiv && (bus.opa == INT_MIN) && (bus.opb == ALL_ONES);
    assign special = div0 || ovf;

    always_comb begin
        special_res = '0;
        if (div0)
            special_res = bus.fnc3[1] ? bus.opa : ALL_ONES;
        else if (ovf)
            special_res = bus.fnc3[1] ? '0 : INT_MIN;
    end

    ex_muldiv_step u_step (
        .is_div  (fnc[2]),
        .acc     (acc),
        .opr     (opr),
        .opd     (opd),
        .acc_nxt (acc_nxt),
        .opr_nxt (opr_nxt)
    );

    // Sign fixup on the magnitude result of the final step.
    always_comb begin
        prod      = {acc_nxt[XLEN-1:0], opr_nxt};
        prod_s    = neg_res ? (~prod + (2*XLEN)'(1)) : prod;
        final_res = '0;
        case (fnc)
            F_MUL:                      final_res = prod_s[XLEN-1:0];
            F_MULH, F_MULHSU, F_MULHU:  final_res = prod_s[2*XLEN-1:XLEN];
            F_DIV, F_DIVU:              final_res = mag(opr_nxt, neg_res);
            default:                    final_res = mag(acc_nxt[XLEN-1:0], neg_rem);
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = special ? ST_DONE : ST_CALC;
            ST_CALC: if (bus.flush) state_nxt = ST_IDLE;
                     else if (last) state_nxt = ST_DONE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            count    <= '0;
            fnc      <= '0;
            rd_q     <= '0;
            rdo_q    <= '0;
            acc      <= '0;
            opr      <= '0;
            opd      <= '0;
            result_q <= '0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                fnc     <= bus.fnc3;
                rd_q    <= bus.rd;
                acc     <= '0;
                opr     <= mag(bus.opa, sgn_a);
                opd     <= mag(bus.opb, sgn_b);
                count   <= '0;
                neg_res <= sgn_a ^ sgn_b;
                neg_rem <= sgn_a;
                if (special) begin
                    result_q <= special_res;
                    rdo_q    <= bus.rd;
                end
            end else if ((state == ST_CALC) && !bus.flush) begin
                acc   <= acc_nxt;
                opr   <= opr_nxt;
                count <= count + CNT_W'(1);
                if (last) begin
                    result_q <= final_res;
                    rdo_q    <= rd_q;
                end
            end
        end
    end

    assign bus.stall  = accept || (state == ST_CALC);
    assign bus.done   = (state == ST_DONE);
    assign bus.result = result_q;
    assign bus.rdo    = rdo_q;

endmodule
